lcd_ctl_fifo: RTL and testbench
===============================

LCD_CTL_FIFO -- requirements
Module: lcd_ctl_fifo

Interface
REQ-001 SHALL have parameter DATA_W, default 16, LCD bus width (1..32).
REQ-002 SHALL have parameter FIFO_DEPTH, default 16, number of queued LCD transfers (power of 2, >=2).
REQ-003 SHALL have parameter TIM_W, default 8, width of each wr_n timing field.
REQ-004 SHALL use one clock and a synchronous, active-high reset: clk_clk  in  1  system clock; reset_reset  in  1  synchronous active-high reset.
REQ-005 SHALL provide avs_address  in  2  register select.
REQ-006 SHALL provide avs_write  in  1  write strobe.
REQ-007 SHALL provide avs_writedata  in  32  write data.
REQ-008 SHALL provide avs_read  in  1  read strobe.
REQ-009 SHALL provide avs_readdata  out  32  read data, valid one cycle after avs_read.
REQ-010 SHALL provide avs_waitrequest  out  1  stall of the current write.
REQ-011 SHALL provide lcd_wr_n  out  1  8080 write strobe, active low.
REQ-012 SHALL provide lcd_data_com_n  out  1  1=data, 0=command.
REQ-013 SHALL provide lcd_data  out  DATA_W  LCD bus.

Function
REQ-014 SHALL decode registers: 0 CMD (push writedata[DATA_W-1:0], com_n=0); 1 DATA (push, com_n=1); 2 TIMING ([TIM_W-1:0]=t_low, [TIM_W+15:16]=t_high); 3 STATUS (read-only).
REQ-015 SHALL read STATUS as bit0 busy (FSM not IDLE), bit1 full, bit2 empty, [15:8] FIFO level; TIMING reads back its value; CMD/DATA read as 0.
REQ-016 SHALL assert avs_waitrequest combinationally when avs_write targets 0/1 and the registered full flag is set; no push occurs while stalled.
REQ-017 SHALL accept a push when not full; a pop in the same cycle as a stalled push does not admit the push until the next cycle.
REQ-018 SHALL run FSM states IDLE, SETUP, WR_LOW, WR_HIGH.
REQ-019 IDLE: FIFO non-empty -> pop, go SETUP next cycle.
REQ-020 SETUP: exactly 1 cycle; lcd_data and lcd_data_com_n driven from popped entry; lcd_wr_n=1; latch t_low/t_high (0 treated as 1).
REQ-021 WR_LOW: lcd_wr_n=0 for t_low cycles; data/com_n held stable.
REQ-022 WR_HIGH: lcd_wr_n=1 for t_high cycles, data held; on last cycle pop and go SETUP if FIFO non-empty, else IDLE.
REQ-023 Per-transfer length SHALL be 1+t_low+t_high cycles; back-to-back transfers SHALL have no idle gap.
REQ-024 TIMING writes during a transfer SHALL affect only transfers whose SETUP follows the write.
REQ-025 lcd_data and lcd_data_com_n SHALL hold their last value in IDLE.
REQ-026 Level counter SHALL be log2(FIFO_DEPTH)+1 bits; pointers wrap modulo FIFO_DEPTH.

Reset
REQ-027 On reset_reset: FSM=IDLE, FIFO empty, lcd_wr_n=1, lcd_data_com_n=1, lcd_data=0, t_low=1, t_high=1, avs_readdata=0, irq=0.
REQ-028 Reset mid-transfer SHALL force lcd_wr_n=1 the following cycle and discard queued entries.

Configuration
REQ-029 With LCD_CTL_IRQ_EN defined: output irq (1 bit) set on FIFO non-empty->empty transition with FSM returning to IDLE; cleared by writing 1 to STATUS bit3; STATUS bit3 reads irq.
REQ-030 Without LCD_CTL_IRQ_EN: no irq port; STATUS bit3 reads 0; writes to STATUS ignored.

Structure
REQ-031 Package lcd_ctl_pkg SHALL hold FSM state enum, register address constants (REG_CMD, REG_DATA, REG_TIMING, REG_STATUS), STATUS bit positions.
REQ-032 FIFO SHALL be sub-module lcd_ctl_sync_fifo (width DATA_W+1, depth FIFO_DEPTH, full/empty/level).

Verification
REQ-033 Write CMD 0x2C, defaults -> lcd_data=0x2C, com_n=0 at SETUP; wr_n low 1 cycle; busy for 3 cycles.
REQ-034 TIMING t_low=3,t_high=2, then DATA 0x1234, 0xABCD -> two 6-cycle transfers, no gap, wr_n low 3 cycles each.
REQ-035 17 DATA writes back-to-back at FIFO_DEPTH=16 -> waitrequest on 17th until first pop; all 17 values appear in order.
REQ-036 TIMING t_low=0 -> wr_n low 1 cycle.
REQ-037 Reset asserted during WR_LOW with 4 entries queued -> wr_n=1 next cycle, STATUS=empty, no further strobes.
REQ-038 With LCD_CTL_IRQ_EN: 2 writes drain -> irq=1; write STATUS bit3=1 -> irq=0 next cycle.

Source files
------------

// File: rtl/lcd_ctl_pkg.sv
// rtl/lcd_ctl_pkg.sv - shared FSM state, register map and STATUS bit layout for lcd_ctl_fifo
package lcd_ctl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETUP   = 2'd1,
        ST_WR_LOW  = 2'd2,
        ST_WR_HIGH = 2'd3
    } lcd_state_e;

    localparam logic [1:0] REG_CMD    = 2'd0;
    localparam logic [1:0] REG_DATA   = 2'd1;
    localparam logic [1:0] REG_TIMING = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;

    localparam int STAT_BUSY    = 0;
    localparam int STAT_FULL    = 1;
    localparam int STAT_EMPTY   = 2;
    localparam int STAT_IRQ     = 3;
    localparam int STAT_LVL_LSB = 8;
    localparam int STAT_LVL_W   = 8;

endpackage

// File: rtl/lcd_ctl_sync_fifo.sv
// rtl/lcd_ctl_sync_fifo.sv - single-clock FIFO with registered level, full and empty flags
module lcd_ctl_sync_fifo #(
    parameter int WIDTH = 17,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW    = $clog2(DEPTH);
    localparam int LVL_W = AW + 1;

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    assign full  = (level_q == LVL_W'(DEPTH));
    assign empty = (level_q == '0);
    assign level = level_q;
    assign rdata = mem_q[rd_ptr_q];

    always_comb begin
        do_push  = push && !full;
        do_pop   = pop && !empty;
        wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = do_pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        level_d  = level_q;
        if (do_push && !do_pop) begin
            level_d = level_q + LVL_W'(1);
        end else if (do_pop && !do_push) begin
            level_d = level_q - LVL_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage needs no reset: the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/lcd_ctl_fifo.sv
// rtl/lcd_ctl_fifo.sv - queued 8080-style LCD write controller with register front end
// Optional completion interrupt output when LCD_CTL_IRQ_EN is defined.
module lcd_ctl_fifo
    import lcd_ctl_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 16,
    parameter int TIM_W      = 8
) (
    input  logic              clk_clk,
    input  logic              reset_reset,
    input  logic [1:0]        avs_address,
    input  logic              avs_write,
    input  logic [31:0]       avs_writedata,
    input  logic              avs_read,
    output logic [31:0]       avs_readdata,
    output logic              avs_waitrequest,
    output logic              lcd_wr_n,
    output logic              lcd_data_com_n,
    output logic [DATA_W-1:0] lcd_data
`ifdef LCD_CTL_IRQ_EN
    ,
    output logic              irq
`endif
);

    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

    function automatic logic [TIM_W-1:0] nz(input logic [TIM_W-1:0] t);
        return (t == '0) ? TIM_W'(1) : t;
    endfunction

    lcd_state_e        state_q, state_d;
    logic [TIM_W-1:0]  cnt_q, cnt_d;
    logic [TIM_W-1:0]  t_low_q, t_low_d, t_high_q, t_high_d;
    logic [TIM_W-1:0]  cur_low_q, cur_low_d, cur_high_q, cur_high_d;
    logic [DATA_W-1:0] lcd_data_q, lcd_data_d;
    logic              com_n_q, com_n_d;
    logic [31:0]       rdata_q, rdata_d, status_word;
    logic              push_addr, fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [DATA_W:0]   fifo_wdata, fifo_rdata;
    logic [LVL_W-1:0]  fifo_level;
    logic              irq_bit;
    logic              unused_wdata;

    assign unused_wdata = ^avs_writedata;

    lcd_ctl_sync_fifo #(
        .WIDTH (DATA_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk_clk),
        .rst   (reset_reset),
        .push  (fifo_push),
        .wdata (fifo_wdata),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    // Stall uses the registered full flag, so a pop this cycle frees space only next cycle.
    always_comb begin
        push_addr       = (avs_address == REG_CMD) || (avs_address == REG_DATA);
        avs_waitrequest = avs_write && push_addr && fifo_full;
        fifo_push       = avs_write && push_addr && !fifo_full;
        fifo_wdata      = {avs_address == REG_DATA, avs_writedata[DATA_W-1:0]};
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        cur_low_d  = cur_low_q;
        cur_high_d = cur_high_q;
        lcd_data_d = lcd_data_q;
        com_n_d    = com_n_q;
        fifo_pop   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    state_d  = ST_SETUP;
                end
            end
            ST_SETUP: begin
                cur_low_d  = nz(t_low_q);
                cur_high_d = nz(t_high_q);
                cnt_d      = TIM_W'(1);
                state_d    = ST_WR_LOW;
            end
            ST_WR_LOW: begin
                if (cnt_q == cur_low_q) begin
                    cnt_d   = TIM_W'(1);
                    state_d = ST_WR_HIGH;
                end else begin
                    cnt_d = cnt_q + TIM_W'(1);
                end
            end
            ST_WR_HIGH: begin
                if (cnt_q == cur_high_q) begin
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        state_d  = ST_SETUP;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + TIM_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (fifo_pop) begin
            {com_n_d, lcd_data_d} = fifo_rdata;
        end
    end

`ifdef LCD_CTL_IRQ_EN
    logic irq_q, irq_d;
    logic drain_done;

    assign drain_done = (state_q == ST_WR_HIGH) && (cnt_q == cur_high_q) && fifo_empty;
    assign irq        = irq_q;
    assign irq_bit    = irq_q;

    always_comb begin
        irq_d = irq_q;
        if (avs_write && (avs_address == REG_STATUS) && avs_writedata[STAT_IRQ]) begin
            irq_d = 1'b0;
        end
        if (drain_done) begin
            irq_d = 1'b1;
        end
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= irq_d;
        end
    end
`else
    assign irq_bit = 1'b0;
`endif

    always_comb begin
        t_low_d  = t_low_q;
        t_high_d = t_high_q;
        if (avs_write && (avs_address == REG_TIMING)) begin
            t_low_d  = avs_writedata[TIM_W-1:0];
            t_high_d = avs_writedata[TIM_W+15:16];
        end

        status_word                                = '0;
        status_word[STAT_BUSY]                     = (state_q != ST_IDLE);
        status_word[STAT_FULL]                     = fifo_full;
        status_word[STAT_EMPTY]                    = fifo_empty;
        status_word[STAT_IRQ]                      = irq_bit;
        status_word[STAT_LVL_LSB +: STAT_LVL_W]    = STAT_LVL_W'(fifo_level);

        rdata_d = rdata_q;
        if (avs_read) begin
            case (avs_address)
                REG_TIMING: rdata_d = (32'(t_high_q) << 16) | 32'(t_low_q);
                REG_STATUS: rdata_d = status_word;
                default:    rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= TIM_W'(1);
            t_low_q    <= TIM_W'(1);
            t_high_q   <= TIM_W'(1);
            cur_low_q  <= TIM_W'(1);
            cur_high_q <= TIM_W'(1);
            lcd_data_q <= '0;
            com_n_q    <= 1'b1;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            t_low_q    <= t_low_d;
            t_high_q   <= t_high_d;
            cur_low_q  <= cur_low_d;
            cur_high_q <= cur_high_d;
            lcd_data_q <= lcd_data_d;
            com_n_q    <= com_n_d;
            rdata_q    <= rdata_d;
        end
    end

    assign lcd_wr_n       = (state_q != ST_WR_LOW);
    assign lcd_data       = lcd_data_q;
    assign lcd_data_com_n = com_n_q;
    assign avs_readdata   = rdata_q;

endmodule

// File: tb/tb_lcd_ctl_fifo.sv
// tb/tb_lcd_ctl_fifo.sv - scoreboard bench for lcd_ctl_fifo (irq checks when LCD_CTL_IRQ_EN is defined)
module tb_lcd_ctl_fifo;

    typedef struct {
        logic        com_n;
        logic [15:0] data;
        int          low;
    } exp_t;

    logic        clk_clk = 1'b0;
    logic        reset_reset = 1'b1;
    logic [1:0]  avs_address = '0;
    logic        avs_write = 1'b0;
    logic [31:0] avs_writedata = '0;
    logic        avs_read = 1'b0;
    logic [31:0] avs_readdata;
    logic        avs_waitrequest;
    logic        lcd_wr_n;
    logic        lcd_data_com_n;
    logic [15:0] lcd_data;
`ifdef LCD_CTL_IRQ_EN
    logic        irq;
`endif

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   exp_low = 1;
    exp_t exp_q[$];
    int   fall_cyc[$];

    lcd_ctl_fifo #(.DATA_W(16), .FIFO_DEPTH(16), .TIM_W(8)) dut (
        .clk_clk         (clk_clk),
        .reset_reset     (reset_reset),
        .avs_address     (avs_address),
        .avs_write       (avs_write),
        .avs_writedata   (avs_writedata),
        .avs_read        (avs_read),
        .avs_readdata    (avs_readdata),
        .avs_waitrequest (avs_waitrequest),
        .lcd_wr_n        (lcd_wr_n),
        .lcd_data_com_n  (lcd_data_com_n),
        .lcd_data        (lcd_data)
`ifdef LCD_CTL_IRQ_EN
        ,
        .irq             (irq)
`endif
    );

    always #5 clk_clk = ~clk_clk;
    always @(posedge clk_clk) cyc <= cyc + 1;

    // Strobe monitor: pops the scoreboard at each falling wr_n, checks bus value and low width.
    logic        prev_wr_n = 1'b1;
    logic [16:0] prev_bus = '0;
    logic        in_pulse = 1'b0;
    int          low_cnt = 0;
    exp_t        cur_e;
    always @(negedge clk_clk) begin
        if (reset_reset) begin
            in_pulse = 1'b0;
        end else if (prev_wr_n && !lcd_wr_n) begin
            fall_cyc.push_back(cyc);
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL strobe_unexpected: got data=%h com_n=%b, required no strobe", lcd_data, lcd_data_com_n);
            end else begin
                cur_e = exp_q.pop_front();
                if ({lcd_data_com_n, lcd_data} !== {cur_e.com_n, cur_e.data} ||
                    prev_bus !== {cur_e.com_n, cur_e.data}) begin
                    errors++;
                    $display("FAIL strobe_bus: got setup=%h low=%h, required %h", prev_bus,
                             {lcd_data_com_n, lcd_data}, {cur_e.com_n, cur_e.data});
                end
                in_pulse = 1'b1;
                low_cnt  = 1;
            end
        end else if (!prev_wr_n && !lcd_wr_n) begin
            low_cnt++;
        end else if (!prev_wr_n && lcd_wr_n && in_pulse) begin
            checks++;
            if (low_cnt != cur_e.low) begin
                errors++;
                $display("FAIL strobe_low_width: got %0d cycles, required %0d", low_cnt, cur_e.low);
            end
            in_pulse = 1'b0;
        end
        prev_wr_n = lcd_wr_n;
        prev_bus  = {lcd_data_com_n, lcd_data};
    end

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d, output int stalls);
        exp_t e;
        avs_address   = a;
        avs_writedata = d;
        avs_write     = 1'b1;
        stalls        = 0;
        @(negedge clk_clk);
        while (avs_waitrequest && stalls < 200) begin
            stalls++;
            @(negedge clk_clk);
        end
        if (a == 2'd0 || a == 2'd1) begin
            e.com_n = a[0];
            e.data  = d[15:0];
            e.low   = exp_low;
            exp_q.push_back(e);
        end
        @(posedge clk_clk);
        #1;
        avs_write = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        avs_address = a;
        avs_read    = 1'b1;
        @(posedge clk_clk);
        #1;
        avs_read = 1'b0;
        d        = avs_readdata;
    endtask

    task automatic set_timing(input int tl, input int th);
        int st;
        bus_write(2'd2, (32'(th) << 16) | 32'(tl), st);
        exp_low = (tl == 0) ? 1 : tl;
    endtask

    task automatic wait_idle(input string tag);
        logic [31:0] s;
        int n;
        n = 0;
        do begin
            bus_read(2'd3, s);
            n++;
        end while (!(s[0] == 1'b0 && s[2] == 1'b1) && n < 3000);
        checks++;
        if (n >= 3000) begin
            errors++;
            $display("FAIL %s_idle: got status=%h after %0d reads, required idle and empty", tag, s, n);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drained: got %0d transfers missing, required 0", tag, exp_q.size());
        end
    endtask

    task automatic test_reset();
        logic [31:0] s;
        checks++;
        if ({lcd_wr_n, lcd_data_com_n, lcd_data, avs_readdata, avs_waitrequest} !== {1'b1, 1'b1, 16'h0, 32'h0, 1'b0}) begin
            errors++;
            $display("FAIL reset_outputs: got wr_n=%b com_n=%b data=%h rd=%h wait=%b, required 1 1 0000 0 0",
                     lcd_wr_n, lcd_data_com_n, lcd_data, avs_readdata, avs_waitrequest);
        end
`ifdef LCD_CTL_IRQ_EN
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b, required 0", irq); end
`endif
        bus_read(2'd3, s);
        checks++;
        if (s !== 32'h0000_0004) begin errors++; $display("FAIL reset_status: got %h, required 00000004", s); end
        bus_read(2'd2, s);
        checks++;
        if (s !== 32'h0001_0001) begin errors++; $display("FAIL reset_timing: got %h, required 00010001", s); end
        bus_read(2'd0, s);
        checks++;
        if (s !== 32'h0) begin errors++; $display("FAIL reset_cmd_read: got %h, required 0", s); end
    endtask

    task automatic test_cmd();
        int st, busy;
        logic [31:0] s, s0;
        bus_write(2'd0, 32'h0000_002C, st);
        avs_address = 2'd3;
        avs_read    = 1'b1;
        busy        = 0;
        s0          = '0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk_clk);
            #1;
            s = avs_readdata;
            if (i == 0) s0 = s;
            busy += int'(s[0]);
        end
        avs_read = 1'b0;
        checks++;
        if (s0[15:0] !== 16'h0100) begin errors++; $display("FAIL cmd_queued_status: got %h, required level 1 not busy", s0); end
        checks++;
        if (busy != 3) begin errors++; $display("FAIL cmd_busy_cycles: got %0d, required 3", busy); end
        wait_idle("cmd");
    endtask

    task automatic test_timing();
        int st, n0;
        logic [31:0] s;
        set_timing(3, 2);
        bus_read(2'd2, s);
        checks++;
        if (s !== 32'h0002_0003) begin errors++; $display("FAIL timing_readback: got %h, required 00020003", s); end
        n0 = fall_cyc.size();
        bus_write(2'd1, 32'h1234, st);
        bus_write(2'd1, 32'hABCD, st);
        wait_idle("timing");
        checks++;
        if (fall_cyc.size() < n0 + 2) begin
            errors++;
            $display("FAIL timing_strobes: got %0d strobes, required 2", fall_cyc.size() - n0);
        end else if (fall_cyc[n0+1] - fall_cyc[n0] != 6) begin
            errors++;
            $display("FAIL timing_period: got %0d cycles, required 6", fall_cyc[n0+1] - fall_cyc[n0]);
        end
    endtask

    task automatic test_full();
        int st;
        logic [31:0] s;
        set_timing(20, 20);
        bus_write(2'd0, 32'h00F0, st);
        for (int i = 1; i <= 16; i++) begin
            bus_write(2'd1, 32'h1000 + 32'(i), st);
            checks++;
            if (st != 0) begin errors++; $display("FAIL full_early_stall: write %0d got %0d stalls, required 0", i, st); end
        end
        bus_read(2'd3, s);
        checks++;
        if (s[1] !== 1'b1 || s[15:8] !== 8'd16) begin
            errors++;
            $display("FAIL full_status: got %h, required full and level 16", s);
        end
        bus_write(2'd1, 32'h1011, st);
        checks++;
        if (st != (1 + 20 + 20) - 16) begin errors++; $display("FAIL full_stall_len: got %0d, required %0d", st, 25); end
        wait_idle("full");
        set_timing(1, 1);
    endtask

    task automatic test_tlow_zero();
        int st, n0;
        logic [31:0] s;
        set_timing(0, 0);
        bus_read(2'd2, s);
        checks++;
        if (s !== 32'h0) begin errors++; $display("FAIL tzero_readback: got %h, required 0", s); end
        n0 = fall_cyc.size();
        bus_write(2'd1, 32'h55AA, st);
        bus_write(2'd0, 32'h00A5, st);
        wait_idle("tzero");
        checks++;
        if (fall_cyc.size() < n0 + 2) begin
            errors++;
            $display("FAIL tzero_strobes: got %0d strobes, required 2", fall_cyc.size() - n0);
        end else if (fall_cyc[n0+1] - fall_cyc[n0] != 3) begin
            errors++;
            $display("FAIL tzero_period: got %0d cycles, required 3", fall_cyc[n0+1] - fall_cyc[n0]);
        end
    endtask

    task automatic test_reset_mid();
        int st, n, n0;
        logic [31:0] s;
        set_timing(5, 5);
        for (int i = 0; i < 5; i++) bus_write(2'd1, 32'h7700 + 32'(i), st);
        n = 0;
        do begin
            @(negedge clk_clk);
            n++;
        end while (lcd_wr_n !== 1'b0 && n < 50);
        checks++;
        if (lcd_wr_n !== 1'b0) begin errors++; $display("FAIL rst_mid_low: got wr_n=%b, required 0", lcd_wr_n); end
        @(posedge clk_clk);
        #1;
        reset_reset = 1'b1;
        @(posedge clk_clk);
        #1;
        checks++;
        if ({lcd_wr_n, lcd_data_com_n, lcd_data, avs_readdata} !== {1'b1, 1'b1, 16'h0, 32'h0}) begin
            errors++;
            $display("FAIL rst_mid_outputs: got wr_n=%b com_n=%b data=%h rd=%h, required 1 1 0000 0",
                     lcd_wr_n, lcd_data_com_n, lcd_data, avs_readdata);
        end
        @(negedge clk_clk);
        @(posedge clk_clk);
        #1;
        reset_reset = 1'b0;
        exp_q.delete();
        exp_low = 1;
        n0 = fall_cyc.size();
        bus_read(2'd3, s);
        checks++;
        if (s !== 32'h0000_0004) begin errors++; $display("FAIL rst_mid_status: got %h, required 00000004", s); end
        repeat (40) @(posedge clk_clk);
        #1;
        checks++;
        if (fall_cyc.size() != n0 || lcd_wr_n !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_quiet: got %0d strobes wr_n=%b, required 0 strobes wr_n=1", fall_cyc.size() - n0, lcd_wr_n);
        end
    endtask

    task automatic test_status_write();
        int st;
        logic [31:0] s;
`ifdef LCD_CTL_IRQ_EN
        bus_write(2'd1, 32'h0101, st);
        bus_write(2'd1, 32'h0202, st);
        wait_idle("irq");
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL irq_set: got %b, required 1", irq); end
        bus_read(2'd3, s);
        checks++;
        if (s !== 32'h0000_000C) begin errors++; $display("FAIL irq_status: got %h, required 0000000c", s); end
        bus_write(2'd3, 32'h8, st);
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL irq_clear: got %b, required 0", irq); end
`else
        bus_write(2'd3, 32'hFFFF_FFFF, st);
        bus_read(2'd3, s);
        checks++;
        if (s !== 32'h0000_0004) begin errors++; $display("FAIL status_write_ignored: got %h, required 00000004", s); end
        bus_write(2'd1, 32'h0303, st);
        wait_idle("status");
        bus_read(2'd3, s);
        checks++;
        if (s[3] !== 1'b0) begin errors++; $display("FAIL status_irq_bit: got %b, required 0", s[3]); end
`endif
    endtask

    initial begin
        repeat (3) @(posedge clk_clk);
        #1;
        reset_reset = 1'b0;
        test_reset();
        test_cmd();
        test_timing();
        test_full();
        test_tlow_zero();
        test_reset_mid();
        test_status_write();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
